// File: rtl/mmio_timer_periph.sv
// mmio_timer_periph: bus-mapped reload timer, tick counter, LED register and 4-digit hex scanner.
// Reads are combinational; writes and all counters update on the rising clock edge.
module mmio_timer_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] Read_data,
    output logic        hit,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [3:0]  an,
    output logic [7:0]  BCD
);
    localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);

    logic [31:0] th, tl, systick, scan_cnt, reg_val;
    logic [2:0]  tcon, off;
    logic [7:0]  led;
    logic [15:0] digi;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic [6:0]  seg;
    logic        wr, ovf, hw_set, scan_wrap, unused_bits;

    assign hit         = Address[31:5] == BASE_ADDR[31:5];
    assign off         = Address[4:2];
    assign wr          = MemWrite && hit;
    assign ovf         = tcon[0] && (tl == 32'hFFFF_FFFF);
    assign hw_set      = ovf && tcon[1];
    assign scan_wrap   = scan_cnt == SCAN_LAST;
    assign unused_bits = ^Address[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            th       <= '0;
            tl       <= '0;
            tcon     <= '0;
            led      <= '0;
            digi     <= '0;
            systick  <= '0;
            scan_cnt <= '0;
            idx      <= '0;
        end else begin
            systick  <= systick + 32'd1;
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 32'd1;
            if (scan_wrap) idx <= idx + 2'd1;
            if (tcon[0]) tl <= ovf ? th : tl + 32'd1;
            if (hw_set) tcon[2] <= 1'b1;
            // Later assignments override the timer updates above, so CPU writes win.
            if (wr) begin
                case (off)
                    3'd0: th   <= Write_data;
                    3'd1: tl   <= Write_data;
                    3'd2: tcon <= {Write_data[2] | hw_set, Write_data[1:0]};
                    3'd3: led  <= Write_data[7:0];
                    3'd4: digi <= Write_data[15:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        reg_val = '0;
        case (off)
            3'd0: reg_val = th;
            3'd1: reg_val = tl;
            3'd2: reg_val = {29'd0, tcon};
            3'd3: reg_val = {24'd0, led};
            3'd4: reg_val = {16'd0, digi};
            3'd5: reg_val = systick;
            default: reg_val = '0;
        endcase
    end

    assign Read_data = (MemRead && hit) ? reg_val : '0;

    assign nib = digi[{idx, 2'b00} +: 4];

    always_comb begin
        seg = 7'h00;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    assign an   = ~(4'b0001 << idx);
    assign BCD  = {1'b1, ~seg};
    assign leds = led;
    assign irq  = tcon[2];
endmodule

// File: tb/tb_mmio_timer_periph.sv
// tb_mmio_timer_periph: directed scenarios plus randomized bus traffic against a cycle-level model.
module tb_mmio_timer_periph;
    localparam int          DIV  = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset, MemWrite, MemRead, hit, irq;
    logic [31:0] Address, Write_data, Read_data;
    logic [7:0]  leds, BCD;
    logic [3:0]  an;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_th, m_tl, m_tick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [15:0] m_digi;
    int          m_cyc;
    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    mmio_timer_periph #(.BASE_ADDR(BASE), .SCAN_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
        .MemWrite(MemWrite), .MemRead(MemRead), .Read_data(Read_data), .hit(hit),
        .irq(irq), .leds(leds), .an(an), .BCD(BCD)
    );

    always #5 clk = ~clk;

    function automatic logic in_win(input logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] exp_read(input logic r, input logic [31:0] a);
        if (!r || !in_win(a)) return 32'd0;
        case (a[4:2])
            3'd0: return m_th;
            3'd1: return m_tl;
            3'd2: return {29'd0, m_tcon};
            3'd3: return {24'd0, m_led};
            3'd4: return {16'd0, m_digi};
            3'd5: return m_tick;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] cur_digit();
        return 2'((m_cyc / DIV) % 4);
    endfunction

    function automatic logic [3:0] exp_an();
        return ~(4'b0001 << cur_digit());
    endfunction

    function automatic logic [7:0] exp_bcd();
        logic [3:0] n;
        n = 4'((m_digi >> (4 * cur_digit())) & 16'hF);
        return {1'b1, ~seg_tab[n]};
    endfunction

    // Apply one clock edge to the model using the inputs currently on the bus.
    task automatic model_step();
        logic ovf;
        if (reset) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_tick = 0; m_cyc = 0;
        end else begin
            ovf = m_tcon[0] && m_tl == 32'hFFFF_FFFF;
            m_tick = m_tick + 1;
            m_cyc = m_cyc + 1;
            if (m_tcon[0]) m_tl = ovf ? m_th : m_tl + 1;
            if (ovf && m_tcon[1]) m_tcon[2] = 1'b1;
            if (MemWrite && in_win(Address)) begin
                case (Address[4:2])
                    3'd0: m_th = Write_data;
                    3'd1: m_tl = Write_data;
                    3'd2: m_tcon = {Write_data[2] | (ovf && m_tcon[1]), Write_data[1:0]};
                    3'd3: m_led = Write_data[7:0];
                    3'd4: m_digi = Write_data[15:0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic drive(input logic rst, input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        reset = rst; MemWrite = w; MemRead = r; Address = a; Write_data = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wr(input int o, input logic [31:0] d);
        drive(0, 1, 0, BASE + 32'(4 * o), d);
        tick();
    endtask

    task automatic rd(input int o);
        drive(0, 0, 1, BASE + 32'(4 * o), 0);
    endtask

    task automatic test_reset();
        drive(1, 0, 0, BASE, 0);
        tick(); tick();
        drive(0, 0, 0, BASE, 0);
        tick();
        total++; if (an !== 4'b1110) begin bad++; $display("FAIL reset_an got=%b want=1110", an); end
        total++; if (BCD !== 8'hC0) begin bad++; $display("FAIL reset_bcd got=%h want=c0", BCD); end
        total++; if (leds !== 8'h00) begin bad++; $display("FAIL reset_leds got=%h want=00", leds); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        for (int o = 0; o < 5; o++) begin
            rd(o);
            total++; if (Read_data !== 32'd0) begin bad++; $display("FAIL reset_read%0d got=%h want=0", o, Read_data); end
        end
        rd(5);
        total++; if (Read_data !== m_tick) begin bad++; $display("FAIL reset_systick got=%h want=%h", Read_data, m_tick); end
        tick();
    endtask

    task automatic test_overflow();
        wr(0, 32'hFFFF_FFFE);
        wr(1, 32'hFFFF_FFFE);
        wr(2, 32'd3);
        rd(1);
        total++; if (Read_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL ovf_k got=%h want=fffffffe", Read_data); end
        tick();
        total++; if (Read_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ovf_k1 got=%h want=ffffffff", Read_data); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL ovf_k1_irq got=%b want=0", irq); end
        tick();
        total++; if (Read_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL ovf_k2 got=%h want=fffffffe", Read_data); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL ovf_k2_irq got=%b want=1", irq); end
    endtask

    task automatic test_irq_clear();
        wr(2, 32'd3);
        rd(1);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL clr_irq got=%b want=0", irq); end
        total++; if (Read_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL clr_tl got=%h want=ffffffff", Read_data); end
        tick(); tick();
        wr(2, 32'd3);
        rd(1);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL ovf_wr_irq got=%b want=1", irq); end
        total++; if (Read_data !== 32'hFFFF_FFFE) begin bad++; $display("FAIL ovf_wr_tl got=%h want=fffffffe", Read_data); end
        wr(2, 32'd0);
    endtask

    task automatic test_scan();
        drive(1, 0, 0, BASE, 0);
        tick();
        wr(4, 32'h1234);
        total++; if (an !== 4'b1110) begin bad++; $display("FAIL scan_d0_an got=%b want=1110", an); end
        total++; if (BCD !== 8'h99) begin bad++; $display("FAIL scan_d0_bcd got=%h want=99", BCD); end
        drive(0, 0, 0, BASE, 0);
        tick(); tick(); tick();
        total++; if (an !== 4'b1101) begin bad++; $display("FAIL scan_d1_an got=%b want=1101", an); end
        total++; if (BCD !== 8'hB0) begin bad++; $display("FAIL scan_d1_bcd got=%h want=b0", BCD); end
        for (int i = 0; i < 16; i++) begin
            tick();
            total++; if (an !== exp_an() || BCD !== exp_bcd())
                begin bad++; $display("FAIL scan_loop%0d got=%b/%h want=%b/%h", i, an, BCD, exp_an(), exp_bcd()); end
        end
        total++; if (an !== 4'b1101 || BCD !== 8'hB0) begin bad++; $display("FAIL scan_repeat got=%b/%h want=1101/b0", an, BCD); end
    endtask

    task automatic test_window();
        drive(0, 1, 1, 32'h0000_0010, 32'hDEAD);
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL win_hit got=%b want=0", hit); end
        total++; if (Read_data !== 32'd0) begin bad++; $display("FAIL win_read got=%h want=0", Read_data); end
        tick();
        rd(4);
        total++; if (Read_data !== 32'h0000_1234) begin bad++; $display("FAIL win_digi got=%h want=1234", Read_data); end
        wr(3, 32'h1A5);
        total++; if (leds !== 8'hA5) begin bad++; $display("FAIL led_out got=%h want=a5", leds); end
        rd(3);
        total++; if (Read_data !== 32'h0000_00A5) begin bad++; $display("FAIL led_read got=%h want=000000a5", Read_data); end
    endtask

    task automatic test_tl_write();
        wr(2, 32'd1);
        wr(1, 32'd5);
        wr(1, 32'h100);
        rd(1);
        total++; if (Read_data !== 32'h100) begin bad++; $display("FAIL tlw_0 got=%h want=100", Read_data); end
        tick();
        total++; if (Read_data !== 32'h101) begin bad++; $display("FAIL tlw_1 got=%h want=101", Read_data); end
        for (int i = 0; i < 8 && exp_an() == 4'b1110; i++) tick();
        total++; if (an === 4'b1110) begin bad++; $display("FAIL midscan_pre got=%b want=not 1110", an); end
        drive(1, 0, 0, BASE, 0);
        tick();
        total++; if (an !== 4'b1110 || BCD !== 8'hC0) begin bad++; $display("FAIL midscan_rst got=%b/%h want=1110/c0", an, BCD); end
        rd(1);
        total++; if (Read_data !== 32'd0) begin bad++; $display("FAIL midscan_tl got=%h want=0", Read_data); end
    endtask

    task automatic test_random();
        logic        w, r, rst;
        logic [31:0] a, d;
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom % 80) == 0;
            w = $urandom % 2;
            r = $urandom % 2;
            a = ($urandom % 8 != 0) ? BASE + ($urandom % 32) : $urandom;
            d = $urandom;
            if (a[4:2] == 3'd1 && $urandom % 2 == 1) d = 32'hFFFF_FFF0 + ($urandom % 16);
            if (a[4:2] == 3'd0 && $urandom % 2 == 1) d = 32'hFFFF_FFFA;
            drive(rst, w, r, a, d);
            total++; if (hit !== in_win(a)) begin bad++; $display("FAIL rnd_hit%0d got=%b want=%b", i, hit, in_win(a)); end
            total++; if (Read_data !== exp_read(r, a)) begin bad++; $display("FAIL rnd_read%0d a=%h got=%h want=%h", i, a, Read_data, exp_read(r, a)); end
            total++; if (irq !== m_tcon[2] || leds !== m_led) begin bad++; $display("FAIL rnd_out%0d got=%b/%h want=%b/%h", i, irq, leds, m_tcon[2], m_led); end
            total++; if (an !== exp_an() || BCD !== exp_bcd()) begin bad++; $display("FAIL rnd_disp%0d got=%b/%h want=%b/%h", i, an, BCD, exp_an(), exp_bcd()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_irq_clear();
        test_scan();
        test_window();
        test_tl_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
